// File: rtl/uart_rx_if.sv
// Bundle of the UART receiver's serial input and byte-side outputs.
// The receiver binds to the slave modport; its stimulus/consumer side uses master.
interface uart_rx_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: mid-bit sampling, start-glitch rejection,
// framing-error pulse, and a cleanup state that waits out a held-low line.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input logic      i_Clock,
  input logic      i_Rst_L,
  uart_rx_if.slave rx_bus
);

  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_count;
  logic [2:0]  r_index;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_byte;
  logic        r_rx_dv;
  logic        r_rx_err;

  logic        w_count_last;
  logic        w_count_half;
  logic        w_active;
  logic        w_sample_bit;
  logic        w_stop_sample;

  assign w_count_last = (r_count == LP_LAST);
  assign w_count_half = (r_count == LP_HALF);

  // The line is asynchronous; only r_sync2 may feed the FSM.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving two real flop stages instead of one collapsed wire.
      r_sync1 <= rx_bus.i_Rx_Serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:    w_next_state = r_sync2 ? S_IDLE : S_START;
      S_START: begin
        if (w_count_half) w_next_state = r_sync2 ? S_IDLE : S_DATA;
        else              w_next_state = S_START;
      end
      S_DATA: begin
        if (w_count_last && (r_index == 3'd7)) w_next_state = S_STOP;
        else                                   w_next_state = S_DATA;
      end
      S_STOP:    w_next_state = w_count_last ? S_CLEANUP : S_STOP;
      S_CLEANUP: w_next_state = r_sync2 ? S_IDLE : S_CLEANUP;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_active      = 1'b0;
    w_sample_bit  = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      S_START: w_active = 1'b1;
      S_DATA: begin
        w_active     = 1'b1;
        w_sample_bit = w_count_last;
      end
      S_STOP: begin
        w_active      = 1'b1;
        w_stop_sample = w_count_last;
      end
      default: ;
    endcase
  end

  // Bit timing: START counts to the half-bit point, DATA/STOP count full bits.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
      r_index <= '0;
    end else begin
      case (r_state)
        S_START: r_count <= w_count_half ? 16'd0 : r_count + 16'd1;
        S_DATA: begin
          r_count <= w_count_last ? 16'd0 : r_count + 16'd1;
          if (w_count_last) r_index <= (r_index == 3'd7) ? 3'd0 : r_index + 3'd1;
        end
        S_STOP:  r_count <= w_count_last ? 16'd0 : r_count + 16'd1;
        default: begin
          r_count <= '0;
          r_index <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      // NOTE: the shift register is reset too; it is only 8 flops and a
      // known value keeps simulation free of X on o_Rx_Byte paths.
      r_shreg   <= '0;
      r_rx_byte <= '0;
      r_rx_dv   <= 1'b0;
      r_rx_err  <= 1'b0;
    end else begin
      if (w_sample_bit) r_shreg[r_index] <= r_sync2;
      if (w_stop_sample && r_sync2) r_rx_byte <= r_shreg;
      r_rx_dv  <= w_stop_sample &&  r_sync2;
      r_rx_err <= w_stop_sample && !r_sync2;
    end
  end

  assign rx_bus.o_Rx_DV        = r_rx_dv;
  assign rx_bus.o_Rx_Byte      = r_rx_byte;
  assign rx_bus.o_Rx_Frame_Err = r_rx_err;
  assign rx_bus.o_Rx_Active    = w_active;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. Sits on the receive side of the UART link, consuming the serial stream the UART transmitter produces, and presents each received byte as a one-cycle valid pulse to the downstream logic. It samples each bit at its midpoint, rejects glitch start bits and flags framing errors.

## Interface
- CLKS_PER_BIT, 217, clock cycles per bit (i_Clock frequency / baud); legal range 4..65535
- i_Clock  input  1  system clock, all logic on rising edge
- i_Rst_L  input  1  asynchronous active-low reset
- i_Rx_Serial  input  1  serial line, asynchronous to i_Clock, idle high
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a new valid byte
- o_Rx_Byte  output  8  last correctly framed byte; held until the next valid byte
- o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- o_Rx_Active  output  1  high while a frame is being received

## Operation
- One clock; reset is asynchronous and active-low, on i_Rst_L.
- Input synchronizer: two flops, sync1 <= i_Rx_Serial, sync2 <= sync1. Both reset to 1. The FSM sees only sync2.
- Clock counter: 16 bits. H = (CLKS_PER_BIT-1)/2, integer division.
- Bit index: 3 bits. Shift register: 8 bits.
- FSM states:
  - IDLE: count=0, index=0. sync2==0 -> START.
  - START: count increments each cycle. At count==H:
    - sync2==0: count=0 -> DATA.
    - sync2==1: glitch -> IDLE, no outputs.
  - DATA: count increments to CLKS_PER_BIT-1. At that value: shreg[index]=sync2, count=0.
    - index<7: index+1, stay in DATA.
    - index==7: index=0 -> STOP.
  - STOP: count increments to CLKS_PER_BIT-1. At that value: count=0 -> CLEANUP.
    - sync2==1: o_Rx_Byte <= shreg, pulse o_Rx_DV.
    - sync2==0: pulse o_Rx_Frame_Err, o_Rx_Byte unchanged.
  - CLEANUP: stay for at least 1 cycle. Leave for IDLE only when sync2==1. This blocks re-triggering on a break or held-low line.
  - Unused encodings -> IDLE.
- o_Rx_Active: 1 in START, DATA and STOP; 0 in IDLE and CLEANUP.
- o_Rx_DV and o_Rx_Frame_Err are registered and mutually exclusive. Each is high for exactly one cycle per frame.

## Timing
- Reset values: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Frame_Err=0, o_Rx_Active=0, state IDLE, counters 0.
- Reset asserted mid-frame: abort immediately, with no DV or error pulse. After release the receiver waits in IDLE for the next falling edge seen on sync2.
- Let edge k be the first clock edge at which sync1 captures the start-bit low.
  - Edge k+2: IDLE -> START. o_Rx_Active high after this edge.
  - Edge k+3+H: start-bit midpoint check.
  - Edge k+3+H+(n+1)*CLKS_PER_BIT: data bit n sampled, n=0..7.
  - Edge k+3+H+9*CLKS_PER_BIT: stop-bit sample. o_Rx_DV or o_Rx_Frame_Err high for the following cycle; o_Rx_Byte updated on the same edge.
  - With the default parameter (H=108), o_Rx_DV asserts after edge k+2064.
- Back-to-back frames: the receiver returns to IDLE about mid stop bit. It must catch a start bit that immediately follows a full-length stop bit.
- Start glitch shorter than H cycles: no output activity. o_Rx_Active is high only for the START dwell.

## Test plan
- CLKS_PER_BIT=16, send 8'hA5 with a correct stop bit -> after edge k+154: o_Rx_DV one cycle, o_Rx_Byte=8'hA5, o_Rx_Frame_Err=0, o_Rx_Active falls on the same edge.
- Loopback from the UART transmitter (same CLKS_PER_BIT), bytes 8'h00, 8'hFF, 8'h3C, 8'h81 back-to-back -> exactly four DV pulses with matching bytes, no errors.
- Low pulse of 5 cycles on an idle line (CLKS_PER_BIT=16) -> no DV, no error, return to IDLE.
- Frame 8'h55 with the stop bit forced low, then line held low for 40 cycles -> one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its previous value. No new frame starts until the line returns high; a following 8'h12 is then received correctly.
- i_Rst_L pulsed low during data bit 4 -> all outputs 0 immediately, no DV for that frame. The next full frame 8'hC3 is received correctly.
- Baud tolerance: transmit with bit period ±3% off nominal (CLKS_PER_BIT=16 sampling) -> bytes received correctly.
